prog_ram_loader: RTL and testbench

- Writer-side counterpart of the program memory: a 16x8 program RAM plus a loader FSM.
- The loader accepts a byte stream over a valid/ready handshake and writes it to consecutive addresses from 0.
- After the data bytes it checks a trailing checksum byte.
- The CPU side has a combinational read port with the same ADDR/Q shape as the program store. The CPU is held via CPU_HOLD while a load is in progress.

---
 rtl/prog_ram_loader.sv | 130 +++++++++++++
 tb/tb_prog_ram_loader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_ram_loader.sv
// prog_ram_loader
//   Program RAM (2**ADDR_WIDTH x DATA_WIDTH) with a stream loader. After START,
//   the loader writes DEPTH bytes taken over a valid/ready handshake to
//   addresses 0..DEPTH-1. It then takes one checksum byte. The data sum plus
//   the checksum must be 0 mod 2**DATA_WIDTH. The CPU read port is
//   combinational and always live.
//
// Ports
//   CLK        system clock, rising edge
//   CLR_N      asynchronous active-low reset (memory contents are kept)
//   START      begin a load, sampled in IDLE only
//   DIN        stream byte
//   DIN_VALID  DIN holds a valid byte
//   DIN_READY  loader accepts DIN this cycle (decoded from state)
//   ADDR       CPU read address
//   Q          mem[ADDR], combinational
//   CPU_HOLD   high while a load is in progress
//   DONE       sticky, set when the last load finished
//   ERR        sticky, set when the last load had a checksum mismatch
//
// state   | meaning
// S_IDLE  | waiting for START; CPU runs
// S_LOAD  | accepting data bytes into mem[wptr]
// S_CHECK | accepting the trailing checksum byte

module prog_ram_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  CLR_N,
  input  logic                  START,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  DIN_VALID,
  output logic                  DIN_READY,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  CPU_HOLD,
  output logic                  DONE,
  output logic                  ERR
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] wptr;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] sum_next;
  logic                  done_r;
  logic                  err_r;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign xfer     = DIN_VALID & DIN_READY;
  assign sum_next = sum + DIN;

  always_comb begin
    state_nxt = state;
    DIN_READY = 1'b0;
    CPU_HOLD  = 1'b0;
    case (state)
      S_IDLE: begin
        if (START) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        DIN_READY = 1'b1;
        CPU_HOLD  = 1'b1;
        // last data address reached: wptr wraps to 0 on this transfer
        if (xfer && (&wptr)) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        DIN_READY = 1'b1;
        CPU_HOLD  = 1'b1;
        if (xfer) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state  <= S_IDLE;
      wptr   <= '0;
      sum    <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (START) begin
            wptr   <= '0;
            sum    <= '0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (xfer) begin
            wptr <= wptr + 1'b1;
            sum  <= sum_next;
          end
        end
        S_CHECK: begin
          if (xfer) begin
            err_r  <= (sum_next != '0);
            done_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // No reset on the array: program contents survive CLR_N.
  always_ff @(posedge CLK) begin
    if (state == S_LOAD && xfer) mem[wptr] <= DIN;
  end

  assign Q    = mem[ADDR];
  assign DONE = done_r;
  assign ERR  = err_r;

endmodule

// File: tb/tb_prog_ram_loader.sv
module tb_prog_ram_loader;

  logic       CLK = 1'b0;
  logic       CLR_N;
  logic       START;
  logic [7:0] DIN;
  logic       DIN_VALID;
  logic       DIN_READY;
  logic [3:0] ADDR;
  logic [7:0] Q;
  logic       CPU_HOLD;
  logic       DONE;
  logic       ERR;

  prog_ram_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .START(START), .DIN(DIN), .DIN_VALID(DIN_VALID),
    .DIN_READY(DIN_READY), .ADDR(ADDR), .Q(Q), .CPU_HOLD(CPU_HOLD),
    .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] model_mem [16];
  logic [7:0] load_data [16];
  logic       exp_q [$];
  int         xfer_cnt = 0;
  logic       hold_q = 1'b0;
  logic       done_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts transfers and scores each completed load against the queue.
  initial begin
    logic e;
    forever begin
      @(negedge CLK);
      if (CPU_HOLD && !hold_q) xfer_cnt = 0;
      if (DONE && !done_q) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("err_flag", ERR, e);
          check("xfer_count", xfer_cnt, 17);
          check("hold_at_done", CPU_HOLD, 0);
        end
      end
      if (DIN_VALID && DIN_READY) xfer_cnt++;
      hold_q = CPU_HOLD;
      done_q = DONE;
    end
  end

  function automatic logic [7:0] data_sum();
    int s = 0;
    for (int i = 0; i < 16; i++) s += load_data[i];
    return 8'(s);
  endfunction

  task automatic check_mem(input string name);
    for (int i = 0; i < 16; i++) begin
      ADDR = 4'(i);
      #1;
      check(name, Q, model_mem[i]);
    end
  endtask

  task automatic wait_scored();
    for (int k = 0; k < 6 && exp_q.size() != 0; k++) @(posedge CLK);
    #1;
    check("done_timeout", exp_q.size(), 0);
  endtask

  // Full load of load_data followed by checksum cs.
  task automatic run_load(input logic [7:0] cs, input bit stall, input int start_at);
    logic [7:0] b;
    exp_q.push_back(8'(data_sum() + cs) != 8'h00);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    check("hold_after_start", CPU_HOLD, 1);
    check("done_cleared", DONE, 0);
    for (int i = 0; i < 17; i++) begin
      b = (i < 16) ? load_data[i] : cs;
      if (stall) begin
        repeat ($urandom_range(0, 2)) begin
          DIN_VALID = 1'b0;
          DIN = 8'($urandom);
          @(posedge CLK); #1;
        end
      end
      if (i == 16) check("done_before_cs", DONE, 0);
      DIN       = b;
      DIN_VALID = 1'b1;
      START     = (i == start_at);
      @(posedge CLK); #1;
      DIN_VALID = 1'b0;
      START     = 1'b0;
    end
    for (int i = 0; i < 16; i++) model_mem[i] = load_data[i];
    wait_scored();
    check("done_after_load", DONE, 1);
  endtask

  initial begin
    logic [7:0] good_vec [16];
    good_vec = '{8'h18, 8'h29, 8'h70, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    CLR_N = 1'b0; START = 1'b0; DIN = '0; DIN_VALID = 1'b0; ADDR = '0;
    #12;
    check("rst_ready", DIN_READY, 0);
    check("rst_hold", CPU_HOLD, 0);
    check("rst_done", DONE, 0);
    check("rst_err", ERR, 0);
    CLR_N = 1'b1;
    @(posedge CLK); #1;

    // Directed good load
    for (int i = 0; i < 16; i++) load_data[i] = good_vec[i];
    run_load(8'h2B, 1'b0, -1);
    check("good_err", ERR, 0);
    check("good_hold", CPU_HOLD, 0);
    ADDR = 4'h0; #1; check("q_addr0", Q, 8'h18);
    ADDR = 4'h2; #1; check("q_addr2", Q, 8'h70);
    ADDR = 4'hF; #1; check("q_addrF", Q, 8'h08);
    check_mem("good_mem");

    // Mid-cycle reset keeps memory
    @(posedge CLK); #3;
    CLR_N = 1'b0; #1;
    check("midrst_ready", DIN_READY, 0);
    check("midrst_hold", CPU_HOLD, 0);
    check("midrst_done", DONE, 0);
    check("midrst_err", ERR, 0);
    #2; CLR_N = 1'b1;
    check_mem("mem_after_reset");
    @(posedge CLK); #1;

    // Bad checksum
    run_load(8'h2C, 1'b0, -1);
    check("bad_err", ERR, 1);
    check_mem("bad_mem");

    // Stalled handshake with a START pulse mid-load
    run_load(8'h2B, 1'b1, 5);
    check("stall_err", ERR, 0);
    check_mem("stall_mem");

    // DIN_VALID in IDLE is ignored
    @(posedge CLK); #1;
    for (int i = 0; i < 4; i++) begin
      DIN = 8'($urandom); DIN_VALID = 1'b1;
      @(posedge CLK); #1;
      check("idle_ready", DIN_READY, 0);
    end
    DIN_VALID = 1'b0;
    check("idle_done_kept", DONE, 1);
    check_mem("idle_mem");

    // Reset after 7 bytes of a new load
    for (int i = 0; i < 16; i++) load_data[i] = 8'($urandom);
    START = 1'b1; @(posedge CLK); #1; START = 1'b0;
    for (int i = 0; i < 7; i++) begin
      DIN = load_data[i]; DIN_VALID = 1'b1;
      @(posedge CLK); #1;
    end
    DIN_VALID = 1'b0;
    for (int i = 0; i < 7; i++) model_mem[i] = load_data[i];
    #2; CLR_N = 1'b0; #1;
    check("abort_done", DONE, 0);
    check("abort_hold", CPU_HOLD, 0);
    #2; CLR_N = 1'b1;
    check_mem("abort_mem");
    @(posedge CLK); #1;
    for (int i = 0; i < 16; i++) load_data[i] = good_vec[i];
    run_load(8'h2B, 1'b0, -1);
    check("reload_err", ERR, 0);
    check_mem("reload_mem");

    // Randomized loads
    for (int t = 0; t < 6; t++) begin
      logic [7:0] cs;
      for (int i = 0; i < 16; i++) load_data[i] = 8'($urandom);
      cs = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'(-data_sum());
      run_load(cs, 1'($urandom_range(0, 1)), int'($urandom_range(0, 20)) - 2);
      check("rand_err", ERR, 8'(data_sum() + cs) != 8'h00);
      check_mem("rand_mem");
    end

    repeat (3) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
